// File: rtl/camera64x64_reader.sv
// Frame reader for a 64x64 8-bit serial camera: trigger burst, wait for frame-ready
// interrupt (with timeout), then clock the frame out over SPI mode 0.
module camera64x64_reader #(
  parameter logic [7:0]  CLKDIV   = 8'h04,
  parameter logic [15:0] NBYTES   = 16'h1000,
  parameter logic [31:0] TMO      = 32'h00075300,
  parameter logic [7:0]  TRIGBITS = 8'h08
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       INT,
  input  logic       LOOKUP,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS_N,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       TMO_ERR,
  output logic       LOOKUP_STAT
);

  // state    | meaning
  // IDLE     | waiting for START
  // TRIG     | TRIGBITS SCLK pulses with CS_N high
  // WAIT_INT | waiting for INT rising edge, timeout counter running
  // READ     | CS_N low, NBYTES*8 SCLK pulses, then CS_N release
  // FIN      | one-cycle DONE, LOOKUP captured
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_INT, READ, FIN} state_t;

  state_t      state_q, state_d;
  logic        int_s1_q, int_s1_d, int_s2_q, int_s2_d, int_prev_q, int_prev_d;
  logic        lk_s1_q, lk_s1_d, lk_s2_q, lk_s2_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  trig_cnt_q, trig_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic        tail_q, tail_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        tmo_err_q, tmo_err_d;
  logic        lookup_stat_q, lookup_stat_d;
  logic        int_rise, div_tc;

  assign int_rise = int_s2_q & ~int_prev_q;
  assign div_tc   = (div_q == 8'd0);

  always_comb begin
    state_d       = state_q;
    int_s1_d      = INT;
    int_s2_d      = int_s1_q;
    int_prev_d    = int_s2_q;
    lk_s1_d       = LOOKUP;
    lk_s2_d       = lk_s1_q;
    div_d         = div_q;
    sclk_d        = sclk_q;
    cs_n_d        = cs_n_q;
    trig_cnt_d    = trig_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    byte_rdy_d    = 1'b0;
    tail_d        = tail_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    tmo_err_d     = 1'b0;
    lookup_stat_d = lookup_stat_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          div_d  = CLKDIV - 8'd1;
          sclk_d = 1'b0;
          if (TRIGBITS == 8'd0) begin
            state_d   = WAIT_INT;
            tmo_cnt_d = 32'd0;
          end else begin
            state_d    = TRIG;
            trig_cnt_d = TRIGBITS;
          end
        end
      end

      TRIG: begin
        if (div_tc) begin
          div_d  = CLKDIV - 8'd1;
          sclk_d = ~sclk_q;
          // a pulse is counted on its falling edge so SCLK ends low
          if (sclk_q) begin
            trig_cnt_d = trig_cnt_q - 8'd1;
            if (trig_cnt_q == 8'd1) begin
              state_d   = WAIT_INT;
              tmo_cnt_d = 32'd0;
            end
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      WAIT_INT: begin
        if (int_rise) begin
          if (NBYTES == 16'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d    = READ;
            cs_n_d     = 1'b0;
            div_d      = CLKDIV - 8'd1;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 16'd0;
            tail_d     = 1'b0;
          end
        end else if (tmo_cnt_q == TMO - 32'd1) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end

      READ: begin
        if (byte_rdy_q) begin
          valid_d = 1'b1;
          data_d  = shift_q;
        end
        if (div_tc) begin
          div_d = CLKDIV - 8'd1;
          if (tail_q) begin
            cs_n_d  = 1'b1;
            state_d = FIN;
            done_d  = 1'b1;
          end else if (!sclk_q) begin
            sclk_d    = 1'b1;
            shift_d   = {shift_q[6:0], MISO};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_rdy_d = 1'b1;
              byte_cnt_d = byte_cnt_q + 16'd1;
            end
          end else begin
            sclk_d = 1'b0;
            if (byte_cnt_q == NBYTES) tail_d = 1'b1;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      FIN: begin
        lookup_stat_d = lk_s2_q;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      int_s1_q      <= 1'b0;
      int_s2_q      <= 1'b0;
      int_prev_q    <= 1'b0;
      lk_s1_q       <= 1'b0;
      lk_s2_q       <= 1'b0;
      div_q         <= 8'd0;
      sclk_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      trig_cnt_q    <= 8'd0;
      tmo_cnt_q     <= 32'd0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 16'd0;
      shift_q       <= 8'd0;
      byte_rdy_q    <= 1'b0;
      tail_q        <= 1'b0;
      data_q        <= 8'd0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      tmo_err_q     <= 1'b0;
      lookup_stat_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_s1_q      <= int_s1_d;
      int_s2_q      <= int_s2_d;
      int_prev_q    <= int_prev_d;
      lk_s1_q       <= lk_s1_d;
      lk_s2_q       <= lk_s2_d;
      div_q         <= div_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      trig_cnt_q    <= trig_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      byte_rdy_q    <= byte_rdy_d;
      tail_q        <= tail_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      tmo_err_q     <= tmo_err_d;
      lookup_stat_q <= lookup_stat_d;
    end
  end

  assign SCLK        = sclk_q;
  assign CS_N        = cs_n_q;
  assign DATA        = data_q;
  assign VALID       = valid_q;
  assign BUSY        = (state_q != IDLE);
  assign DONE        = done_q;
  assign TMO_ERR     = tmo_err_q;
  assign LOOKUP_STAT = lookup_stat_q;

endmodule

// File: tb/tb_camera64x64_reader.sv
// Directed bench for camera64x64_reader: table of whole-frame scenarios plus
// hand-written sequences for stale INT, START during READ and mid-frame reset.
module tb_camera64x64_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       int_in = 1'b0;
  logic       lookup = 1'b0;
  logic       miso = 1'b0;
  logic       sclk, cs_n, valid, busy, done, tmo_err, lookup_stat;
  logic [7:0] data;

  always #5 clk = ~clk;

  camera64x64_reader #(
    .CLKDIV(8'd2), .NBYTES(16'd4), .TMO(32'd100), .TRIGBITS(8'd8)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .INT(int_in), .LOOKUP(lookup),
    .MISO(miso), .SCLK(sclk), .CS_N(cs_n), .DATA(data), .VALID(valid),
    .BUSY(busy), .DONE(done), .TMO_ERR(tmo_err), .LOOKUP_STAT(lookup_stat)
  );

  typedef struct {
    int          int_dly;   // cycles after trigger end before INT rises; -1 = never
    logic        lk;
    logic [31:0] bytes;     // first byte in [31:24]
    logic        exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // monitor state
  int          trig_rises, trig_falls, read_rises, valid_cnt, done_cnt, tmo_cnt;
  int          tmo_at, wcnt;
  logic        cs_low, done_prev, ls_after, sclk_prev;
  logic [7:0]  cap [8];
  logic [31:0] cur_bytes;
  logic        exp_ls = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Counts SCLK edges, strobes, and drives MISO MSB-first ahead of each READ rise.
  initial begin
    sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sclk && !sclk_prev) begin
          if (cs_n) trig_rises++;
          else      read_rises++;
        end
        if (!sclk && sclk_prev && cs_n) begin
          trig_falls++;
          if (trig_falls == 8) wcnt = 0;
          else wcnt++;
        end else begin
          wcnt++;
        end
        if (!cs_n) cs_low = 1'b1;
        if (valid) begin
          if (valid_cnt < 8) cap[valid_cnt] = data;
          valid_cnt++;
        end
        if (done) done_cnt++;
        if (done_prev) ls_after = lookup_stat;
        done_prev = done;
        if (tmo_err) begin
          tmo_cnt++;
          tmo_at = wcnt;
        end
        if (read_rises < 32) miso = cur_bytes[31 - read_rises];
        else miso = 1'b0;
      end
      sclk_prev = sclk;
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    trig_rises = 0; trig_falls = 0; read_rises = 0; valid_cnt = 0;
    done_cnt = 0; tmo_cnt = 0; tmo_at = -1; wcnt = 0;
    cs_low = 1'b0; done_prev = 1'b0; ls_after = 1'bx;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic start_frame(input vec_t v);
    int k;
    clear_mon();
    cur_bytes = v.bytes;
    lookup = v.lk;
    pulse_start();
    k = 0;
    while (trig_falls < 8 && k < 400) begin @(negedge clk); k++; end
    check("trigger_burst_end", (trig_falls >= 8) ? 1 : 0, 1);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (done_cnt == 0 && tmo_cnt == 0 && k < 3000) begin @(negedge clk); k++; end
    check("frame_end_seen", (done_cnt + tmo_cnt > 0) ? 1 : 0, 1);
  endtask

  task automatic check_results(input vec_t v);
    check("trig_pulses", trig_rises, 8);
    if (v.exp_done) begin
      exp_ls = v.lk;
      check("read_pulses", read_rises, 32);
      check("valid_count", valid_cnt, 4);
      for (int i = 0; i < 4; i++)
        check($sformatf("data_byte%0d", i), int'(cap[i]), int'(v.bytes[31 - 8*i -: 8]));
      check("done_count", done_cnt, 1);
      check("tmo_err_count", tmo_cnt, 0);
      check("lookup_after_done", int'(ls_after), int'(exp_ls));
    end else begin
      check("read_pulses_tmo", read_rises, 0);
      check("valid_count_tmo", valid_cnt, 0);
      check("done_count_tmo", done_cnt, 0);
      check("tmo_err_count", tmo_cnt, 1);
      // registered strobe, first visible right after the 100th WAIT_INT cycle
      check("tmo_err_cycle", tmo_at, 100);
      check("cs_stayed_high", int'(cs_low), 0);
    end
    check("busy_after", int'(busy), 0);
    check("lookup_stat", int'(lookup_stat), int'(exp_ls));
    check("sclk_idle", int'(sclk), 0);
    check("cs_n_idle", int'(cs_n), 1);
  endtask

  task automatic run_vec(input vec_t v);
    start_frame(v);
    if (v.int_dly >= 0) begin
      repeat (v.int_dly) @(negedge clk);
      int_in = 1'b1;
    end
    wait_end();
    int_in = 1'b0;
    repeat (6) @(negedge clk);
    check_results(v);
  endtask

  vec_t vecs [5];

  initial begin
    int k;
    int rr_at_rst;
    vec_t v;

    vecs[0] = '{int_dly: 20, lk: 1'b1, bytes: 32'hA53CFF00, exp_done: 1'b1};
    vecs[1] = '{int_dly: 20, lk: 1'b0, bytes: 32'h5AC30180, exp_done: 1'b1};
    vecs[2] = '{int_dly: -1, lk: 1'b1, bytes: 32'h00000000, exp_done: 1'b0};
    vecs[3] = '{int_dly: 5,  lk: 1'b0, bytes: 32'h12345678, exp_done: 1'b1};
    vecs[4] = '{int_dly: 60, lk: 1'b1, bytes: 32'hFE01807F, exp_done: 1'b1};

    cur_bytes = 32'h0;
    trig_rises = 0; trig_falls = 0; read_rises = 0; valid_cnt = 0;
    done_cnt = 0; tmo_cnt = 0; tmo_at = -1; wcnt = 0;
    cs_low = 1'b0; done_prev = 1'b0; ls_after = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_sclk", int'(sclk), 0);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tmo_err", int'(tmo_err), 0);
    check("rst_lookup_stat", int'(lookup_stat), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // INT already high before START: only a fresh rise inside WAIT_INT starts READ
    v = '{int_dly: 0, lk: 1'b0, bytes: 32'hC0FFEE11, exp_done: 1'b1};
    int_in = 1'b1;
    repeat (5) @(negedge clk);
    start_frame(v);
    repeat (30) @(negedge clk);
    check("stale_int_no_read", read_rises, 0);
    check("stale_int_busy", int'(busy), 1);
    int_in = 1'b0;
    repeat (4) @(negedge clk);
    int_in = 1'b1;
    wait_end();
    int_in = 1'b0;
    repeat (6) @(negedge clk);
    check_results(v);

    // START during READ is ignored
    v = '{int_dly: 10, lk: 1'b1, bytes: 32'h8142A5DB, exp_done: 1'b1};
    start_frame(v);
    repeat (10) @(negedge clk);
    int_in = 1'b1;
    k = 0;
    while (valid_cnt < 1 && k < 500) begin @(negedge clk); k++; end
    check("first_valid_seen", (valid_cnt >= 1) ? 1 : 0, 1);
    pulse_start();
    wait_end();
    int_in = 1'b0;
    repeat (6) @(negedge clk);
    check_results(v);
    repeat (40) @(negedge clk);
    check("restart_ignored_busy", int'(busy), 0);
    check("restart_ignored_trig", trig_rises, 8);

    // reset after the second byte aborts immediately
    v = '{int_dly: 10, lk: 1'b1, bytes: 32'h11223344, exp_done: 1'b1};
    start_frame(v);
    repeat (10) @(negedge clk);
    int_in = 1'b1;
    k = 0;
    while (valid_cnt < 2 && k < 500) begin @(negedge clk); k++; end
    check("second_valid_seen", (valid_cnt >= 2) ? 1 : 0, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sclk", int'(sclk), 0);
    check("abort_cs_n", int'(cs_n), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_data", int'(data), 0);
    check("abort_lookup_stat", int'(lookup_stat), 0);
    exp_ls = 1'b0;
    int_in = 1'b0;
    repeat (3) @(negedge clk);
    rr_at_rst = read_rises;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_sclk", read_rises + trig_rises, rr_at_rst + 8);
    check("post_rst_idle", int'(busy), 0);
    run_vec('{int_dly: 20, lk: 1'b0, bytes: 32'hDEADBEEF, exp_done: 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
